// File: rtl/countdown.sv
// Countdown timer stage: latches the BCD preset from setup on start and counts it down to 00 at a 1 s rate.
// Build option COUNTDOWN_BLINK_EN: alarm blinks 1 s on / 1 s off in DONE instead of following done.
module countdown #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] set_hi,
  input  logic [3:0] set_lo,
  input  logic       set_seconds,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] hi,
  output logic [3:0] lo,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned     PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    hi_q, hi_d, lo_q, lo_d;
  logic          unit_q, unit_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]    sec_q, sec_d;
`ifdef COUNTDOWN_BLINK_EN
  logic          alarm_q, alarm_d;
`endif

  logic          tick;
  logic [PW-1:0] pre_next;
  logic [3:0]    pv_hi, pv_lo, dec_hi, dec_lo;
  logic          pv_nonzero, dec_to_zero;

  function automatic logic [3:0] bcd_sat(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    tick        = (pre_q == PRE_LAST);
    pre_next    = tick ? '0 : pre_q + 1'b1;
    pv_hi       = bcd_sat(set_hi);
    pv_lo       = bcd_sat(set_lo);
    pv_nonzero  = (pv_hi != 4'd0) || (pv_lo != 4'd0);
    // Borrow from the tens digit; 00 never decrements further.
    if (lo_q != 4'd0) begin
      dec_hi = hi_q;
      dec_lo = lo_q - 4'd1;
    end else if (hi_q != 4'd0) begin
      dec_hi = hi_q - 4'd1;
      dec_lo = 4'd9;
    end else begin
      dec_hi = hi_q;
      dec_lo = lo_q;
    end
    dec_to_zero = (dec_hi == 4'd0) && (dec_lo == 4'd0);
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unit_d  = unit_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
`ifdef COUNTDOWN_BLINK_EN
    alarm_d = alarm_q;
`endif
    case (state_q)
      S_IDLE: begin
        hi_d = pv_hi;
        lo_d = pv_lo;
        if (start_stop && pv_nonzero) begin
          state_d = S_RUN;
          unit_d  = set_seconds;
          pre_d   = '0;
          sec_d   = '0;
        end
      end
      S_RUN: begin
        // Prescaler advances even on the pause edge; a tick coinciding with pause is dropped.
        pre_d = pre_next;
        if (start_stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          if (unit_q || (sec_q == 6'd59)) begin
            sec_d = '0;
            hi_d  = dec_hi;
            lo_d  = dec_lo;
            if (dec_to_zero) begin
              state_d = S_DONE;
`ifdef COUNTDOWN_BLINK_EN
              alarm_d = 1'b1;
`endif
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      S_PAUSE: begin
        if (start_stop) state_d = S_RUN;
      end
      default: begin
`ifdef COUNTDOWN_BLINK_EN
        pre_d = pre_next;
        if (tick) alarm_d = ~alarm_q;
`endif
        if (start_stop) begin
          state_d = S_IDLE;
          hi_d    = pv_hi;
          lo_d    = pv_lo;
`ifdef COUNTDOWN_BLINK_EN
          alarm_d = 1'b0;
`endif
        end
      end
    endcase
    if (clear) begin
      state_d = S_IDLE;
      hi_d    = pv_hi;
      lo_d    = pv_lo;
      pre_d   = '0;
      sec_d   = '0;
`ifdef COUNTDOWN_BLINK_EN
      alarm_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      unit_q  <= 1'b0;
      pre_q   <= '0;
      sec_q   <= '0;
`ifdef COUNTDOWN_BLINK_EN
      alarm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      unit_q  <= unit_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
`ifdef COUNTDOWN_BLINK_EN
      alarm_q <= alarm_d;
`endif
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
`ifdef COUNTDOWN_BLINK_EN
  assign alarm   = alarm_q;
`else
  assign alarm   = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_countdown.sv
// Directed bench for countdown with TICK_DIV=4 (one tick every 4 cycles).
module tb_countdown;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] set_hi = 4'd0, set_lo = 4'd0;
  logic       set_seconds = 1'b1, start_stop = 1'b0, clear = 1'b0;
  logic [3:0] hi, lo;
  logic       running, done, alarm;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  countdown #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .set_hi(set_hi), .set_lo(set_lo),
    .set_seconds(set_seconds), .start_stop(start_stop), .clear(clear),
    .hi(hi), .lo(lo), .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic preset(input logic [3:0] h, input logic [3:0] l, input logic secs);
    set_hi = h;
    set_lo = l;
    set_seconds = secs;
    step(1);
  endtask

  initial begin
    step(2);
    chk("rst_hi", 32'(hi), 0);
    chk("rst_lo", 32'(lo), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_alarm", 32'(alarm), 0);
    reset = 1'b0;

    // 0/3 seconds: decrements every 4 cycles
    preset(4'd0, 4'd3, 1'b1);
    chk("a_preview", 32'(lo), 3);
    pulse_ss();
    chk("a_running", 32'(running), 1);
    step(3);
    chk("a_lo_hold", 32'(lo), 3);
    step(1);
    chk("a_lo2", 32'(lo), 2);
    step(4);
    chk("a_lo1", 32'(lo), 1);
    step(3);
    chk("a_not_done", 32'(done), 0);
    step(1);
    chk("a_lo0", 32'(lo), 0);
    chk("a_done", 32'(done), 1);
    chk("a_run_off", 32'(running), 0);
    chk("a_alarm_entry", 32'(alarm), 1);
    step(4);
`ifdef COUNTDOWN_BLINK_EN
    chk("a_blink_off", 32'(alarm), 0);
    step(4);
    chk("a_blink_on", 32'(alarm), 1);
`else
    chk("a_alarm_steady", 32'(alarm), 1);
`endif
    pulse_ss();
    chk("a_ack_done", 32'(done), 0);
    chk("a_ack_alarm", 32'(alarm), 0);
    step(1);
    chk("a_ack_lo", 32'(lo), 3);

    // 1/0 seconds: borrow then down to 00
    preset(4'd1, 4'd0, 1'b1);
    pulse_ss();
    step(4);
    chk("b_hi_borrow", 32'(hi), 0);
    chk("b_lo_borrow", 32'(lo), 9);
    step(35);
    chk("b_lo1", 32'(lo), 1);
    chk("b_not_done", 32'(done), 0);
    step(1);
    chk("b_done", 32'(done), 1);
    chk("b_lo0", 32'(lo), 0);
    pulse_ss();

    // 0/0 start is ignored
    preset(4'd0, 4'd0, 1'b1);
    pulse_ss();
    chk("c_running", 32'(running), 0);
    step(5);
    chk("c_running_later", 32'(running), 0);
    chk("c_done", 32'(done), 0);

    // Invalid BCD loads as 9
    preset(4'd12, 4'd15, 1'b1);
    step(1);
    chk("inv_hi", 32'(hi), 9);
    chk("inv_lo", 32'(lo), 9);

    // 0/2 minutes: 240 cycles per decrement, unit flag ignored mid-run
    preset(4'd0, 4'd2, 1'b0);
    pulse_ss();
    step(100);
    set_seconds = 1'b1;
    step(139);
    chk("d_lo2", 32'(lo), 2);
    step(1);
    chk("d_lo1", 32'(lo), 1);
    chk("d_running", 32'(running), 1);
    step(239);
    chk("d_not_done", 32'(done), 0);
    step(1);
    chk("d_done", 32'(done), 1);
    chk("d_lo0", 32'(lo), 0);
    pulse_ss();

    // Pause 2 cycles into the second period, resume, decrement 2 cycles later
    preset(4'd0, 4'd3, 1'b1);
    pulse_ss();
    step(4);
    chk("e_lo2", 32'(lo), 2);
    step(1);
    pulse_ss();
    chk("e_paused", 32'(running), 0);
    step(20);
    chk("e_hold_lo", 32'(lo), 2);
    pulse_ss();
    chk("e_resumed", 32'(running), 1);
    step(1);
    chk("e_lo_still2", 32'(lo), 2);
    step(1);
    chk("e_lo1", 32'(lo), 1);

    // clear wins over simultaneous start_stop
    clear = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
    chk("f_running", 32'(running), 0);
    chk("f_done", 32'(done), 0);
    step(1);
    chk("f_preview", 32'(lo), 3);

    // Async reset between edges
    pulse_ss();
    step(5);
    chk("g_pre_lo", 32'(lo), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("g_async_running", 32'(running), 0);
    chk("g_async_lo", 32'(lo), 0);
    chk("g_async_done", 32'(done), 0);
    step(1);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
